// File: rtl/write_to_ddr3.sv
// Avalon-MM burst write master: drains the pixel FIFO into two DDR3 frame buffers,
// owns the buffer full flags, and offers a single-word test write between frames.
module write_to_ddr3 #(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 1024,
  parameter int BURST_LEN    = 4
) (
  input  logic         ddr3_clk,
  input  logic         ddr3_reset_n,
  input  logic [25:0]  ddr3_buffer0_offset,
  input  logic [25:0]  ddr3_buffer1_offset,
  input  logic         clear_buffer0,
  input  logic         clear_buffer1,
  output logic         ddr3_wr_buffer0_full,
  output logic         ddr3_wr_buffer1_full,
  input  logic [127:0] data_fifo_q,
  input  logic [9:0]   data_fifo_usedw,
  output logic         data_fifo_rd,
  input  logic         test_wr,
  input  logic [31:0]  test_addr,
  input  logic [127:0] test_wr_data,
  output logic         test_wr_done,
  input  logic         ddr3_avl_ready,
  output logic         ddr3_avl_burstbegin,
  output logic         ddr3_avl_write_req,
  output logic [2:0]   ddr3_avl_size,
  output logic [25:0]  ddr3_avl_addr,
  output logic [127:0] ddr3_avl_wdata,
  output logic [15:0]  ddr3_avl_be,
  output logic         in_frame
);
  localparam int FRAME_BURSTS = (IMAGE_WIDTH * IMAGE_HEIGHT) / (4 * BURST_LEN);
  localparam int BCW = $clog2(FRAME_BURSTS + 1);
  localparam int BTW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, TEST_WRITE, WAIT_DATA, WRITE_BURST} state_t;

  state_t         state;
  logic           buffer_sel;
  logic [BTW-1:0] beat;
  logic [BCW-1:0] burst_cnt;
  logic           sel_full, oth_full;
  logic           burst_end, frame_end;
  logic           set0, set1;
  logic           unused_addr_hi;

  assign unused_addr_hi = ^test_addr[31:26];

  assign sel_full  = buffer_sel ? ddr3_wr_buffer1_full : ddr3_wr_buffer0_full;
  assign oth_full  = buffer_sel ? ddr3_wr_buffer0_full : ddr3_wr_buffer1_full;
  assign burst_end = (state == WRITE_BURST) && ddr3_avl_ready && (beat == BTW'(BURST_LEN - 1));
  assign frame_end = burst_end && (burst_cnt == BCW'(FRAME_BURSTS - 1));
  assign set0      = frame_end && !buffer_sel;
  assign set1      = frame_end &&  buffer_sel;

  // Bus strobes follow state and the registered beat counter directly.
  assign ddr3_avl_write_req  = (state == TEST_WRITE) || (state == WRITE_BURST);
  assign ddr3_avl_burstbegin = (state == TEST_WRITE) || ((state == WRITE_BURST) && (beat == '0));
  assign ddr3_avl_wdata      = (state == TEST_WRITE) ? test_wr_data : data_fifo_q;
  assign data_fifo_rd        = (state == WRITE_BURST) && ddr3_avl_ready;
  assign ddr3_avl_be         = '1;

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      state                <= IDLE;
      buffer_sel           <= 1'b0;
      ddr3_wr_buffer0_full <= 1'b0;
      ddr3_wr_buffer1_full <= 1'b0;
      ddr3_avl_addr        <= '0;
      ddr3_avl_size        <= '0;
      beat                 <= '0;
      burst_cnt            <= '0;
      in_frame             <= 1'b0;
      test_wr_done         <= 1'b0;
    end else begin
      test_wr_done <= 1'b0;
      // A set on the final beat overrides a coincident clear.
      ddr3_wr_buffer0_full <= set0 | (ddr3_wr_buffer0_full & ~clear_buffer0);
      ddr3_wr_buffer1_full <= set1 | (ddr3_wr_buffer1_full & ~clear_buffer1);
      case (state)
        IDLE: begin
          // test_wr is still high the cycle done pulses; don't re-issue it.
          if (test_wr && !test_wr_done) begin
            ddr3_avl_addr <= test_addr[25:0];
            ddr3_avl_size <= 3'd1;
            state         <= TEST_WRITE;
          end else if (!sel_full) begin
            ddr3_avl_addr <= buffer_sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
            ddr3_avl_size <= 3'(BURST_LEN);
            burst_cnt     <= '0;
            in_frame      <= 1'b1;
            state         <= WAIT_DATA;
          end else if (!oth_full) begin
            buffer_sel <= ~buffer_sel;
          end
        end
        TEST_WRITE: begin
          if (ddr3_avl_ready) begin
            test_wr_done <= 1'b1;
            state        <= IDLE;
          end
        end
        WAIT_DATA: begin
          if (data_fifo_usedw >= 10'(BURST_LEN)) begin
            beat  <= '0;
            state <= WRITE_BURST;
          end
        end
        WRITE_BURST: begin
          if (ddr3_avl_ready) begin
            if (burst_end) begin
              beat          <= '0;
              ddr3_avl_addr <= ddr3_avl_addr + 26'(BURST_LEN);
              burst_cnt     <= burst_cnt + 1'b1;
              if (frame_end) begin
                buffer_sel <= ~buffer_sel;
                in_frame   <= 1'b0;
                state      <= IDLE;
              end else begin
                state <= WAIT_DATA;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
